// File: rtl/umac_s2b_pkg.sv
// Shared types and constants for the MAC16 family of bitstream-to-binary decoders.
package umac_s2b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_WIN_LOG2   = 8;
  localparam int DEF_SCALE_LOG2 = 4;

  // Signed result width: count bits plus sign plus the adder scale restore.
  function automatic int out_width(input int win_log2, input int scale_log2);
    return win_log2 + scale_log2 + 2;
  endfunction

endpackage

// File: rtl/uones_cnt.sv
// Window ones/sample counter: counts ones over 2^WIN_LOG2 enabled samples.
module uones_cnt #(
  parameter int WIN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [WIN_LOG2:0] ones,
  output logic [WIN_LOG2:0] final_cnt,
  output logic              done
);

  localparam logic [WIN_LOG2-1:0] SAMPLE_ONE = 1;

  logic [WIN_LOG2-1:0] samples;

  // done marks the edge that consumes the last bit of the window; final_cnt
  // already includes that bit so the caller can latch it on the same edge.
  assign done      = en && (samples == '1);
  assign final_cnt = ones + {{WIN_LOG2{1'b0}}, din};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones    <= '0;
      samples <= '0;
    end else if (clr) begin
      ones    <= '0;
      samples <= '0;
    end else if (en) begin
      ones    <= final_cnt;
      samples <= samples + SAMPLE_ONE;
    end
  end

endmodule

// File: rtl/umac_bi_scaled_s2b.sv
// Bipolar scaled stochastic MAC output decoder: ones count over a window,
// converted to a signed fixed-point dot product with valid/ready delivery.
module umac_bi_scaled_s2b
  import umac_s2b_pkg::*;
#(
  parameter int WIN_LOG2   = DEF_WIN_LOG2,
  parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
  parameter int OUT_W      = out_width(WIN_LOG2, SCALE_LOG2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iBit,
  input  logic                    iEn,
  input  logic                    iStart,
  input  logic                    iAbort,
  input  logic                    iReady,
  output logic                    oBusy,
  output logic                    oValid,
  output logic [WIN_LOG2:0]       oCnt,
  output logic signed [OUT_W-1:0] oVal
);

  localparam logic [WIN_LOG2+1:0] WIN_LEN = {2'b01, {WIN_LOG2{1'b0}}};

  state_t state, state_next;

  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    cnt_done;
  logic [WIN_LOG2:0]       cnt_ones;
  logic [WIN_LOG2:0]       cnt_final;
  logic signed [WIN_LOG2+1:0] diff;
  logic signed [OUT_W-1:0]    val_next;

  // Abort is folded in here so a window can never complete on an abort edge.
  assign cnt_en = (state == ACC) && iEn && !iAbort;

  uones_cnt #(
    .WIN_LOG2(WIN_LOG2)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .din      (iBit),
    .ones     (cnt_ones),
    .final_cnt(cnt_final),
    .done     (cnt_done)
  );

  // 2*count - L lies in -L..+L, so the modular subtraction is exact in
  // WIN_LOG2+2 bits; the scale shift then restores the 1/16 adder weighting.
  assign diff     = $signed({cnt_final, 1'b0} - WIN_LEN);
  assign val_next = OUT_W'(diff) <<< SCALE_LOG2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    if (iAbort) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (iStart) begin
          state_next = ACC;
          cnt_clr    = 1'b1;
        end
        ACC: if (cnt_done) state_next = HOLD;
        HOLD: if (iReady) begin
          if (iStart) begin
            state_next = ACC;
            cnt_clr    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Flags are registered from next-state so they change with the state flop;
  // results survive an abort and are only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oBusy  <= 1'b0;
      oValid <= 1'b0;
      oCnt   <= '0;
      oVal   <= '0;
    end else begin
      oBusy  <= (state_next == ACC);
      oValid <= (state_next == HOLD);
      if (cnt_done) begin
        oCnt <= cnt_final;
        oVal <= val_next;
      end
    end
  end

endmodule

// File: tb/tb_umac_bi_scaled_s2b.sv
// Self-checking bench for umac_bi_scaled_s2b: behavioural window model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_umac_bi_scaled_s2b;

  localparam int WL = 8;
  localparam int SL = 4;
  localparam int OW = WL + SL + 2;
  localparam int L  = 1 << WL;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic iBit   = 1'b0;
  logic iEn    = 1'b0;
  logic iStart = 1'b0;
  logic iAbort = 1'b0;
  logic iReady = 1'b0;
  logic                 oBusy;
  logic                 oValid;
  logic [WL:0]          oCnt;
  logic signed [OW-1:0] oVal;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  umac_bi_scaled_s2b #(
    .WIN_LOG2  (WL),
    .SCALE_LOG2(SL),
    .OUT_W     (OW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iBit  (iBit),
    .iEn   (iEn),
    .iStart(iStart),
    .iAbort(iAbort),
    .iReady(iReady),
    .oBusy (oBusy),
    .oValid(oValid),
    .oCnt  (oCnt),
    .oVal  (oVal)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 waiting, 1 collecting bits, 2 result offered.
  int m_phase, m_seen, m_ones, m_cnt, m_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_seen = 0; m_ones = 0; m_cnt = 0; m_val = 0;
    end else if (iAbort) begin
      m_phase = 0; m_seen = 0; m_ones = 0;
    end else if (m_phase == 0) begin
      if (iStart) begin m_phase = 1; m_seen = 0; m_ones = 0; end
    end else if (m_phase == 1) begin
      if (iEn) begin
        m_seen += 1;
        m_ones += int'(iBit);
        if (m_seen == L) begin
          m_cnt   = m_ones;
          m_val   = (2 * m_ones - L) * (1 << SL);
          m_phase = 2;
        end
      end
    end else if (iReady) begin
      if (iStart) begin m_phase = 1; m_seen = 0; m_ones = 0; end
      else m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy",  longint'(oBusy),  longint'(m_phase == 1));
      check("model_valid", longint'(oValid), longint'(m_phase == 2));
      check("model_cnt",   longint'(oCnt),   longint'(m_cnt));
      check("model_val",   longint'(oVal),   longint'(m_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = k[7-i];
    return r;
  endfunction

  // Emulated MAC output for iA=0xFF, iB=0x80: counter and bit-reversed counter
  // SNGs, bipolar multiply by XNOR; all 16 lanes are identical so the mux is moot.
  function automatic logic mac_bit(input int k);
    logic a, b;
    a = (k < 255);
    b = (rev8(8'(k)) < 8'd128);
    return ~(a ^ b);
  endfunction

  // pat: 0 ones, 1 zeros, 2 alternating 1/0, 3 random, 4 emulated MAC
  task automatic feed(input int n, input int pat, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      iEn = 1'b1;
      case (pat)
        0:       iBit = 1'b1;
        1:       iBit = 1'b0;
        2:       iBit = (i % 2 == 0);
        3:       iBit = 1'($urandom);
        default: iBit = mac_bit(i);
      endcase
      ones += int'(iBit);
      // iStart during a window must be ignored
      iStart = (pat == 3) && ($urandom_range(0, 15) == 0);
      tick();
    end
    iEn    = 1'b0;
    iStart = 1'b0;
    iBit   = 1'($urandom);
  endtask

  task automatic expect_result(input string name, input int cnt, input int val);
    check({name, "_valid"}, longint'(oValid), 1);
    check({name, "_busy"},  longint'(oBusy),  0);
    check({name, "_cnt"},   longint'(oCnt),   longint'(cnt));
    check({name, "_val"},   longint'(oVal),   longint'(val));
  endtask

  int ones, prev_cnt, prev_val;

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #10;
    check("reset_busy",  longint'(oBusy),  0);
    check("reset_valid", longint'(oValid), 0);
    check("reset_cnt",   longint'(oCnt),   0);
    check("reset_val",   longint'(oVal),   0);
    tick();
    rst_n = 1'b1;
    tick();

    // All ones, all zeros, alternating; consumer always ready
    iReady = 1'b1;
    do_start();
    check("start_busy", longint'(oBusy), 1);
    feed(L, 0, ones);
    expect_result("ones", 256, 4096);
    tick();
    check("ones_pulse_end", longint'(oValid), 0);

    do_start();
    feed(L, 1, ones);
    expect_result("zeros", 0, -4096);
    tick();

    do_start();
    feed(L, 2, ones);
    expect_result("alt", 128, 0);
    tick();

    // Stalled input: valid on odd cycles, ones on every 4th valid bit,
    // iBit forced high on stall cycles to prove they are ignored
    do_start();
    for (int c = 0; c < 2 * L; c++) begin
      iEn  = (c % 2 == 1);
      iBit = iEn ? ((c / 2) % 4 == 0) : 1'b1;
      tick();
      if (c == 2 * L - 2) check("gated_not_early", longint'(oValid), 0);
    end
    iEn = 1'b0;
    expect_result("gated", 64, -2048);
    tick();

    // Back-pressure: result held, iStart ignored, then zero-bubble restart
    iReady = 1'b0;
    do_start();
    feed(L, 3, ones);
    expect_result("hold", ones, (2 * ones - L) * 16);
    prev_cnt = ones;
    for (int k = 0; k < 20; k++) begin
      iStart = (k == 5);
      tick();
      check("hold_valid", longint'(oValid), 1);
      check("hold_cnt",   longint'(oCnt),   longint'(prev_cnt));
    end
    iReady = 1'b1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("b2b_busy",  longint'(oBusy),  1);
    check("b2b_valid", longint'(oValid), 0);
    feed(L, 3, ones);
    expect_result("b2b", ones, (2 * ones - L) * 16);
    prev_cnt = ones;
    prev_val = (2 * ones - L) * 16;
    tick();

    // Abort mid-window: results retained, no valid
    do_start();
    feed(100, 3, ones);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("abort_busy",  longint'(oBusy),  0);
    check("abort_valid", longint'(oValid), 0);
    check("abort_cnt",   longint'(oCnt),   longint'(prev_cnt));
    check("abort_val",   longint'(oVal),   longint'(prev_val));
    iAbort = 1'b1;
    iStart = 1'b1;
    tick();
    iAbort = 1'b0;
    iStart = 1'b0;
    check("abort_start_idle", longint'(oBusy), 0);
    for (int k = 0; k < 5; k++) tick();
    check("abort_no_valid", longint'(oValid), 0);

    // Asynchronous reset mid-window
    do_start();
    feed(150, 3, ones);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  longint'(oBusy),  0);
    check("arst_valid", longint'(oValid), 0);
    check("arst_cnt",   longint'(oCnt),   0);
    check("arst_val",   longint'(oVal),   0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    feed(L, 3, ones);
    expect_result("post_rst", ones, (2 * ones - L) * 16);
    tick();

    // Emulated MAC: true dot product is 0.0, tolerance 0.5 => |oVal| <= 128
    do_start();
    feed(L, 4, ones);
    expect_result("mac", 129, 32);
    check("mac_tol", longint'((oVal <= 128) && (oVal >= -128)), 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
